// File: rtl/an_encoder_pkg.sv
// an_encoder_pkg
// Shared constants and types for the AN-code encoder and its matching decoder.
//   A     : the AN-code multiplier (37)
//   A_W   : bit width of A
//   N_W   : data word width
//   AN_W  : codeword width, wide enough that A*N never overflows
//   CNT_W : width of the shift-add bit counter
//   an_state_e : encoder FSM states
//   a_bit()    : selects one bit of A, reading 0 past its top bit
package an_encoder_pkg;

    localparam int A_W   = 6;
    localparam int N_W   = 12;
    localparam int AN_W  = N_W + A_W;
    localparam int CNT_W = 3;

    localparam logic [A_W-1:0] A = 6'd37;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } an_state_e;

    // The counter can index past A's top bit, so pad A out to the counter's
    // full range and read zeros there.
    function automatic logic a_bit(input logic [CNT_W-1:0] idx);
        logic [(1<<CNT_W)-1:0] a_ext;
        a_ext = {{((1<<CNT_W)-A_W){1'b0}}, A};
        return a_ext[idx];
    endfunction

endpackage

// File: rtl/an_shift_add_mul.sv
// an_shift_add_mul
// Sequential shift-add multiplier computing A*N one bit of A per cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start_i    : latch n_i, clear the accumulator and the bit counter
//   step_i     : process bit cnt of A (add N<<cnt when that bit is 1)
//   n_i        : data word N
//   acc_o      : running accumulator (A*N once all A_W bits are processed)
//   last_o     : the bit currently indexed is the top bit of A
module an_shift_add_mul
    import an_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [N_W-1:0]  n_i,
    output logic [AN_W-1:0] acc_o,
    output logic            last_o
);

    logic [N_W-1:0]   n_q,   n_d;
    logic [AN_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AN_W-1:0]  n_shift_s;

    // Next-state logic for the datapath: load, one shift-add step, or hold.
    always_comb begin
        n_d       = n_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        // N is widened to the full codeword width before shifting so no
        // partial product loses its high bits.
        n_shift_s = {{A_W{1'b0}}, n_q} << cnt_q;
        if (start_i) begin
            n_d   = n_i;
            acc_d = {AN_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else if (step_i) begin
            if (a_bit(cnt_q)) begin
                acc_d = acc_q + n_shift_s;
            end else begin
                acc_d = acc_q;
            end
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            n_d   = n_q;
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Datapath registers; reset discards any partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= {N_W{1'b0}};
            acc_q <= {AN_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            n_q   <= n_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(A_W - 1));

endmodule

// File: rtl/an_encoder.sv
// an_encoder
// AN-code encoder: accepts a 12-bit word N and delivers the codeword 37*N.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   in_valid   : N offered on in_n
//   in_ready   : N accepted this cycle (only in IDLE)
//   in_n       : data word N
//   out_valid  : codeword presented on out_an (only in HOLD)
//   out_ready  : consumer takes out_an this cycle
//   out_an     : codeword A*N, forced to 0 whenever out_valid is low
//   busy       : FSM is in MUL or HOLD
//   enc_count  : number of delivered codewords, wrapping silently
module an_encoder
    import an_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_W-1:0]  in_n,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AN_W-1:0] out_an,
    output logic            busy,
    output logic [15:0]     enc_count
);

    an_state_e       state_q, state_d;
    logic [15:0]     enc_count_q, enc_count_d;
    logic            start_s;
    logic            step_s;
    logic            last_s;
    logic [AN_W-1:0] acc_s;

    an_shift_add_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_s),
        .step_i  (step_s),
        .n_i     (in_n),
        .acc_o   (acc_s),
        .last_o  (last_s)
    );

    // Next-state, datapath control and delivery counting.
    always_comb begin
        state_d     = state_q;
        enc_count_d = enc_count_q;
        start_s     = 1'b0;
        step_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    start_s = 1'b1;
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_HOLD: begin
                // A word offered alongside out_ready is not taken here;
                // in_ready only rises once back in IDLE.
                if (out_ready) begin
                    enc_count_d = enc_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            enc_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            enc_count_q <= enc_count_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MUL) || (state_q == ST_HOLD);
    assign out_an    = (state_q == ST_HOLD) ? acc_s : {AN_W{1'b0}};
    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_an_encoder.sv
// tb_an_encoder
// Directed and randomised checks of an_encoder: reset state, latency,
// back-to-back words, stalled output, reset mid-multiply, counter wrap,
// and a reference decode of every delivered codeword.
module tb_an_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_n;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_an;
    logic        busy;
    logic [15:0] enc_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count;

    an_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_an    (out_an),
        .busy      (busy),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Offer one word from IDLE; returns at the negedge of the first MUL cycle.
    task automatic send(input logic [11:0] n);
        in_n     = n;
        in_valid = 1'b1;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("busy_mul", 32'(busy), 32'd1);
        check_eq("in_ready_mul", 32'(in_ready), 32'd0);
    endtask

    // Remaining five MUL cycles: nothing visible on the output yet.
    task automatic mul_wait();
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("mul_no_valid", 32'(out_valid), 32'd0);
            check_eq("mul_an_zero", 32'(out_an), 32'd0);
            check_eq("mul_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    // Codeword appears at k+6; stall, then take it with a competing in_valid.
    task automatic deliver(input logic [11:0] n, input logic [17:0] exp, input int stall);
        @(posedge clk);
        @(negedge clk);
        check_eq("latency_valid", 32'(out_valid), 32'd1);
        check_eq("out_an", 32'(out_an), 32'(exp));
        check_eq("an_mod37", 32'(out_an) % 32'd37, 32'd0);
        check_eq("an_decode", 32'(out_an) / 32'd37, 32'(n));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = s[0];
            in_n      = 12'hABC;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_an", 32'(out_an), 32'(exp));
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_n      = 12'h123;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_count = exp_count + 16'd1;
        check_eq("idle_valid", 32'(out_valid), 32'd0);
        check_eq("idle_an_zero", 32'(out_an), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("enc_count", 32'(enc_count), 32'(exp_count));
    endtask

    initial begin
        // Reset with a word already waiting: it is taken on the first edge after release.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_n      = 12'd0;
        out_ready = 1'b1;
        exp_count = 16'd0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_an", 32'(out_an), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_enc_count", 32'(enc_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("first_accept_busy", 32'(busy), 32'd1);
        mul_wait();
        deliver(12'd0, 18'd0, 0);

        // Back-to-back words.
        send(12'd1);    mul_wait(); deliver(12'd1,    18'd37,     0);
        send(12'd564);  mul_wait(); deliver(12'd564,  18'd20868,  0);
        send(12'd4095); mul_wait(); deliver(12'd4095, 18'd151515, 0);

        // Stalled consumer with in_valid toggling.
        send(12'd100);  mul_wait(); deliver(12'd100,  18'd3700,   10);

        // Reset in the third MUL cycle discards the operation.
        send(12'd200);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_enc_count", 32'(enc_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 16'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
            check_eq("midrst_an_zero", 32'(out_an), 32'd0);
        end
        check_eq("midrst_count_zero", 32'(enc_count), 32'd0);
        send(12'd2); mul_wait(); deliver(12'd2, 18'd74, 2);

        // Random words with random stalls; expected value from a plain multiply.
        for (int w = 0; w < 200; w++) begin
            logic [11:0] n;
            logic [17:0] e;
            n = 12'($urandom_range(0, 4095));
            e = 18'(37 * int'(n));
            send(n);
            mul_wait();
            deliver(n, e, int'($urandom_range(0, 3)));
        end

        // Counter wrap: preload 65535 deliveries, then deliver one more.
        force dut.enc_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.enc_count_q;
        @(posedge clk);
        @(negedge clk);
        exp_count = 16'hFFFF;
        check_eq("preload_count", 32'(enc_count), 32'd65535);
        send(12'd5); mul_wait(); deliver(12'd5, 18'd185, 0);
        check_eq("wrap_zero", 32'(enc_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/an_encoder.md
AN_ENCODER -- requirements
Module: an_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset; assertion is immediate, release is sampled on clk.
REQ-004 in_valid  input  1  a data word N is offered on in_n.
REQ-005 in_ready  output  1  the block accepts N this cycle.
REQ-006 in_n  input  12  data word N, unsigned.
REQ-007 out_valid  output  1  codeword AN is presented on out_an.
REQ-008 out_ready  input  1  the consumer takes out_an this cycle.
REQ-009 out_an  output  18  codeword A*N, unsigned, with A=37.
REQ-010 busy  output  1  the FSM is not in IDLE.
REQ-011 enc_count  output  16  number of codewords delivered.

Function
REQ-012 Constants: A=37, A_W=6, N_W=12, AN_W=N_W+A_W=18; no intermediate value SHALL be truncated below AN_W bits.
REQ-013 FSM states: IDLE, MUL, HOLD.
REQ-014 IDLE: in_ready=1, out_valid=0.
  - On in_valid=1: latch N, clear acc and bit counter cnt, go to MUL.
REQ-015 MUL: in_ready=0.
  - Each cycle: if A[cnt]=1, acc <= acc + (N << cnt); then cnt++.
  - After cnt=A_W-1 is processed, go to HOLD.
  - MUL lasts exactly A_W=6 cycles.
REQ-016 HOLD: out_valid=1, out_an=acc, held stable while out_ready=0.
  - On out_ready=1: return to IDLE and increment enc_count.
REQ-017 Latency: with a handshake at rising edge k, out_valid SHALL be 1 from the edge at k+6 onward.
REQ-018 Throughput: at most one codeword per 8 cycles; in_ready=0 in MUL and HOLD.
  - in_valid arriving outside IDLE SHALL be ignored and not latched.
REQ-019 Encoding correctness: every delivered out_an SHALL equal 37*in_n.
  - Equivalently, out_an % 37 == 0 and out_an / 37 == in_n, which is exactly what the matching AN decoder checks.
REQ-020 out_an SHALL read 0 whenever out_valid=0.
REQ-021 enc_count SHALL wrap from 65535 to 0 without a flag.
REQ-022 Simultaneous out_ready=1 in HOLD and in_valid=1: the new word SHALL NOT be accepted in that cycle.
  - in_ready rises only in IDLE, on the following cycle.
REQ-023 busy SHALL be 1 exactly in MUL and HOLD.

Reset
REQ-024 rst_n=0 SHALL immediately force:
  - state=IDLE, acc=0, cnt=0, latched N=0, enc_count=0;
  - hence in_ready=1, out_valid=0, out_an=0, busy=0.
REQ-025 Reset during MUL or HOLD SHALL discard the operation in progress; no partial codeword is ever presented and enc_count is not incremented.
REQ-026 The first acceptance after reset release SHALL occur on the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-027 A shared package SHALL hold:
  - constants A, A_W, N_W, AN_W;
  - the FSM state enum.
  The decoder side reuses the same constants from this package.
REQ-028 The shift-add datapath (acc, cnt, N register) SHALL be one sub-module, an_shift_add_mul.
  - The FSM and handshake stay in an_encoder.

Verification
REQ-029 in_n=0, out_ready=1 -> out_an=0 at k+6; enc_count=1.
REQ-030 in_n=1, then in_n=564, then in_n=4095, back-to-back with out_ready=1 -> out_an=37, 20868, 151515; every value %37==0.
REQ-031 in_n=100 with out_ready=0 for 10 cycles, in_valid toggling meanwhile -> out_an=3700 held stable, in_ready=0 throughout; a single delivery once out_ready=1.
REQ-032 Assert rst_n=0 at cycle 3 of MUL for in_n=200 -> out_valid never rises for 7400, enc_count=0; next in_n=2 -> out_an=74.
REQ-033 Preload 65535 deliveries, then one more -> enc_count=0.
REQ-034 Random 10k words with random out_ready -> each out_an=37*in_n in order; a reference AN decoder fed out_an returns in_n exactly.
